// File: rtl/ramdp_pkg.sv
// ramdp_pkg: shared types, reset constants and pointer helpers for the
// RAMDP FIFO controller.
//
// Pointers are carried in a fixed-width container (ptr_t). Only the low
// asz+1 bits are meaningful, and bit asz is the wrap bit. The helpers take
// the address width as an argument, so one package can serve any
// AddrSize < PTR_W_MAX.
package ramdp_pkg;

    localparam int PTR_W_MAX = 16;

    typedef logic [PTR_W_MAX-1:0] ptr_t;

    localparam ptr_t PTR_RST  = '0;
    localparam logic RDY_RST  = 1'b1;
    localparam logic VLD_RST  = 1'b0;
    localparam logic AF_RST   = 1'b0;

    // Covers the wrap bit plus the address bits.
    function automatic ptr_t ptr_mask(input int asz);
        return ptr_t'((32'd1 << (asz + 1)) - 32'd1);
    endfunction

    // Incrementing modulo 2*depth keeps the wrap bit toggling once per lap.
    function automatic ptr_t ptr_inc(input ptr_t p, input int asz);
        return (p + ptr_t'(1)) & ptr_mask(asz);
    endfunction

    function automatic logic ptr_empty(input ptr_t w, input ptr_t r);
        return (w == r);
    endfunction

    // Full means the address bits match and the wrap bits differ. Under the
    // mask, the XOR of the two pointers is then exactly the wrap bit.
    function automatic logic ptr_full(input ptr_t w, input ptr_t r, input int asz);
        ptr_t wrap_bit;
        wrap_bit = ptr_t'(32'd1 << asz);
        return (((w ^ r) & ptr_mask(asz)) == wrap_bit);
    endfunction

endpackage

// File: rtl/ramdp_fifo_ptr.sv
// ramdp_fifo_ptr: one FIFO pointer register with wrap.
//
// Ports:
//   clock  in   rising-edge clock
//   reset  in   asynchronous active-low reset
//   clear  in   synchronous return to zero (flush); it has priority over inc
//   inc    in   advance the pointer by one
//   ptr    out  AddrSize+1 bit pointer; the MSB is the wrap bit
module ramdp_fifo_ptr
    import ramdp_pkg::*;
#(
    parameter int AddrSize = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    input  logic                inc,
    output logic [AddrSize:0]   ptr
);

    logic [AddrSize:0] ptr_nxt;

    always_comb begin
        ptr_nxt = ptr;
        if (clear) begin
            ptr_nxt = '0;
        end else if (inc) begin
            ptr_nxt = (AddrSize+1)'(ptr_inc(ptr_t'(ptr), AddrSize));
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr <= (AddrSize+1)'(PTR_RST);
        end else begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/ramdp_fifo_ctrl.sv
// ramdp_fifo_ctrl: first-word-fall-through FIFO controller placed in front
// of a RAMDP dual-port RAM. RAMDP is instantiated by the parent.
//
// Ports:
//   clock, reset             clock, asynchronous active-low reset
//   flush                    synchronous clear; it beats any push or pop
//   in_valid/in_ready/in_data     push stream
//   out_valid/out_ready/out_data  pop stream; out_data is ram_rdata
//   count                    occupancy, 0..2^AddrSize
//   ram_we/ram_waddr/ram_wdata    RAMDP write port (we/addr0/data_i)
//   ram_raddr/ram_rdata      RAMDP read port (addr1/data_o1)
//   almost_full              registered watermark flag; it exists only when
//                            RAMDP_FIFO_WATERMARK_EN is defined
//
// There is no bypass: a word written at edge N is presented at edge N+1,
// because RAMDP reads addr1 combinationally.
module ramdp_fifo_ctrl
    import ramdp_pkg::*;
#(
    parameter int AddrSize   = 4,
    parameter int DataSize   = 8,
    parameter int AlmostFull = (1 << AddrSize) - 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DataSize-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DataSize-1:0]  out_data,
    output logic [AddrSize:0]    count,
    output logic                 ram_we,
    output logic [AddrSize-1:0]  ram_waddr,
    output logic [DataSize-1:0]  ram_wdata,
    output logic [AddrSize-1:0]  ram_raddr,
    input  logic [DataSize-1:0]  ram_rdata
`ifdef RAMDP_FIFO_WATERMARK_EN
    ,
    output logic                 almost_full
`endif
);

    logic [AddrSize:0] wptr;
    logic [AddrSize:0] rptr;
    logic [AddrSize:0] count_nxt;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    ramdp_fifo_ptr #(.AddrSize(AddrSize)) u_wptr (
        .clock (clock),
        .reset (reset),
        .clear (flush),
        .inc   (push),
        .ptr   (wptr)
    );

    ramdp_fifo_ptr #(.AddrSize(AddrSize)) u_rptr (
        .clock (clock),
        .reset (reset),
        .clear (flush),
        .inc   (pop),
        .ptr   (rptr)
    );

    // The flags depend only on the pointer registers. That keeps in_ready
    // free of any path from out_ready, so a full queue refuses a push even
    // in a cycle where it is popped.
    assign full      = ptr_full(ptr_t'(wptr), ptr_t'(rptr), AddrSize);
    assign empty     = ptr_empty(ptr_t'(wptr), ptr_t'(rptr));
    assign in_ready  = !full;
    assign out_valid = !empty;

    assign push = in_valid  & in_ready  & !flush;
    assign pop  = out_valid & out_ready & !flush;

    assign ram_we    = push;
    assign ram_waddr = wptr[AddrSize-1:0];
    assign ram_wdata = in_data;
    assign ram_raddr = rptr[AddrSize-1:0];
    assign out_data  = ram_rdata;

    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else if (push && !pop) begin
            count_nxt = count + 1'b1;
        end else if (pop && !push) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

`ifdef RAMDP_FIFO_WATERMARK_EN
    localparam logic [AddrSize:0] AF_LEVEL = (AddrSize+1)'(AlmostFull);

    // The flag is computed from the next count, so it changes on the same
    // edge as count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            almost_full <= AF_RST;
        end else begin
            almost_full <= (count_nxt >= AF_LEVEL);
        end
    end
`endif

endmodule

// File: tb/tb_ramdp_fifo_ctrl.sv
module tb_ramdp_fifo_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int D  = 16;
    localparam int AF = D - 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW:0]   count;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_rdata;
`ifdef RAMDP_FIFO_WATERMARK_EN
    logic          almost_full;
`endif

    ramdp_fifo_ctrl #(.AddrSize(AW), .DataSize(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .ram_we    (ram_we),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata)
`ifdef RAMDP_FIFO_WATERMARK_EN
        ,
        .almost_full (almost_full)
`endif
    );

    // Behavioural RAMDP: the write happens on the clock edge, the read is
    // combinational.
    logic [DW-1:0] mem [D];
    always @(posedge clock) if (ram_we) mem[ram_waddr] <= ram_wdata;
    assign ram_rdata = mem[ram_raddr];

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a queue of words plus the total number of words
    // written and read since the last clear.
    logic [DW-1:0] model_q[$];
    int wr_cnt = 0;
    int rd_cnt = 0;

    typedef struct {
        logic          iv;
        logic [DW-1:0] d;
        logic          ordy;
        logic          exp_rdy;
        logic          exp_ov;
        logic [AW:0]   exp_cnt;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        model_q.delete();
        wr_cnt = 0;
        rd_cnt = 0;
    endtask

    task automatic model_update(input logic iv, input logic [DW-1:0] d,
                                input logic ordy, input logic fl);
        int  sz;
        bit  push_ok;
        bit  pop_ok;
        sz      = model_q.size();
        push_ok = iv && (sz < D) && !fl;
        pop_ok  = ordy && (sz > 0) && !fl;
        if (fl) begin
            model_clear();
        end else begin
            if (pop_ok) begin
                void'(model_q.pop_front());
                rd_cnt++;
            end
            if (push_ok) begin
                model_q.push_back(d);
                wr_cnt++;
            end
        end
    endtask

    // Runs one cycle. Inputs are applied just after a rising edge, and the
    // outputs are compared with the model at the falling edge.
    task automatic step(input logic iv, input logic [DW-1:0] d,
                        input logic ordy, input logic fl);
        int sz;
        bit push_ok;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(negedge clock);
        sz      = model_q.size();
        push_ok = iv && (sz < D) && !fl;
        chk("in_ready",  32'(in_ready),  32'(sz < D));
        chk("out_valid", 32'(out_valid), 32'(sz > 0));
        chk("count",     32'(count),     32'(sz));
        chk("ram_we",    32'(ram_we),    32'(push_ok));
        chk("ram_waddr", 32'(ram_waddr), 32'(wr_cnt % D));
        chk("ram_raddr", 32'(ram_raddr), 32'(rd_cnt % D));
        if (sz > 0) chk("out_data", 32'(out_data), 32'(model_q[0]));
        if (push_ok) chk("ram_wdata", 32'(ram_wdata), 32'(d));
`ifdef RAMDP_FIFO_WATERMARK_EN
        chk("almost_full", 32'(almost_full), 32'(sz >= AF));
`endif
        @(posedge clock);
        #1;
        model_update(iv, d, ordy, fl);
    endtask

    initial begin
        // Cycles 0-3 push BB, AA, EF, AE; cycles 4-7 pop them; cycle 8 is idle.
        vt[0] = '{1'b1, 8'hBB, 1'b0, 1'b1, 1'b0, 5'd0, 8'h00};
        vt[1] = '{1'b1, 8'hAA, 1'b0, 1'b1, 1'b1, 5'd1, 8'hBB};
        vt[2] = '{1'b1, 8'hEF, 1'b0, 1'b1, 1'b1, 5'd2, 8'hBB};
        vt[3] = '{1'b1, 8'hAE, 1'b0, 1'b1, 1'b1, 5'd3, 8'hBB};
        vt[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 5'd4, 8'hBB};
        vt[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 5'd3, 8'hAA};
        vt[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 5'd2, 8'hEF};
        vt[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 5'd1, 8'hAE};
        vt[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 8'h00};

        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        #3;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_ram_we",    32'(ram_we),    32'd0);
        chk("rst_waddr",     32'(ram_waddr), 32'd0);
        chk("rst_raddr",     32'(ram_raddr), 32'd0);
`ifdef RAMDP_FIFO_WATERMARK_EN
        chk("rst_almost_full", 32'(almost_full), 32'd0);
`endif
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        model_clear();

        // Vector table
        for (int i = 0; i < 9; i++) begin
            in_valid  = vt[i].iv;
            in_data   = vt[i].d;
            out_ready = vt[i].ordy;
            flush     = 1'b0;
            @(negedge clock);
            chk("vec_in_ready",  32'(in_ready),  32'(vt[i].exp_rdy));
            chk("vec_out_valid", 32'(out_valid), 32'(vt[i].exp_ov));
            chk("vec_count",     32'(count),     32'(vt[i].exp_cnt));
            if (vt[i].exp_ov) chk("vec_out_data", 32'(out_data), 32'(vt[i].exp_data));
            @(posedge clock);
            #1;
            model_update(vt[i].iv, vt[i].d, vt[i].ordy, 1'b0);
        end

        // Asynchronous reset in the middle of a run, with count = 5
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        chk("pre_rst_count", 32'(count), 32'd5);
        in_valid = 1'b0;
        reset    = 1'b0;
        #2;
        chk("async_rst_count",     32'(count),     32'd0);
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_in_ready",  32'(in_ready),  32'd1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        model_clear();

        // Fill to full, push while full, pop and push together while full, wrap
        for (int i = 0; i < D; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_count",    32'(count),    32'd16);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        chk("push_full_count", 32'(count), 32'd16);
        chk("full_head", 32'(out_data), 32'h00);
        step(1'b1, 8'h77, 1'b1, 1'b0);
        chk("full_pp_count",    32'(count),    32'd15);
        chk("full_pp_in_ready", 32'(in_ready), 32'd1);
        step(1'b1, 8'h77, 1'b0, 1'b0);
        chk("full_pp_next_count", 32'(count), 32'd16);
        for (int i = 0; i < D; i++) begin
            chk("wrap_data", 32'(out_data), (i < D - 1) ? 32'(i + 1) : 32'h77);
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("drain_out_valid", 32'(out_valid), 32'd0);
        chk("drain_count",     32'(count),     32'd0);

        // Push into an empty queue with out_ready held high: there is no bypass
        step(1'b1, 8'h5A, 1'b1, 1'b0);
        chk("nobypass_out_valid", 32'(out_valid), 32'd1);
        chk("nobypass_data",      32'(out_data),  32'h5A);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("nobypass_popped", 32'(out_valid), 32'd0);

        // Flush together with a push while count = 3
        for (int i = 1; i <= 3; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        chk("pre_flush_count", 32'(count), 32'd3);
        in_valid = 1'b1;
        in_data  = 8'h33;
        flush    = 1'b1;
        @(negedge clock);
        chk("flush_no_we", 32'(ram_we), 32'd0);
        @(posedge clock);
        #1;
        model_update(1'b1, 8'h33, 1'b0, 1'b1);
        chk("flush_count",     32'(count),     32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_waddr",     32'(ram_waddr), 32'd0);

`ifdef RAMDP_FIFO_WATERMARK_EN
        for (int i = 0; i < D; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            chk("af_edge", 32'(almost_full), 32'(i + 1 >= AF));
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
`endif

        // Randomised traffic: a push-heavy phase, then a pop-heavy phase
        for (int i = 0; i < 600; i++) begin
            logic iv;
            logic ordy;
            logic fl;
            iv   = (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            ordy = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 79) == 0);
            step(iv, 8'($urandom), ordy, fl);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
